// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch prediction path (IF lookup and EX resolution).
package btb_pkg;

   localparam int unsigned INSTR_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic        hit;
      logic        taken;
      logic [31:0] target;
   } pred_entry_t;

   // Next fetch PC implied by a BTB lookup result.
   function automatic logic [31:0] next_pc(input logic        hit,
                                           input logic        taken,
                                           input logic [31:0] target,
                                           input logic [31:0] pc);
      return (hit && taken) ? target : pc + 32'(INSTR_BYTES);
   endfunction

endpackage

// File: rtl/pred_fifo.sv
// Prediction queue between IF and EX; flush clears pointers in one cycle.
module pred_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = btb_pkg::pred_entry_t,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push_i,
   input  T            push_data_i,
   input  logic        pop_i,
   input  logic        flush_i,
   output T            head_o,
   output logic        full_o,
   output logic        empty_o,
   output logic [AW:0] count_o
);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   T            mem_q [DEPTH];

   // Extra MSB distinguishes full from empty when the indices match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/btb_resolve.sv
// EX-stage branch resolution: compares queued predictions with actual outcomes,
// trains the BTB, redirects fetch on mispredict and keeps statistics.
module btb_resolve
   import btb_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fetch_valid,
   output logic             fetch_ready,
   input  logic [31:0]      fetch_pc,
   input  logic             pred_valid,
   input  logic             pred_taken,
   input  logic [31:0]      pred_target,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic             ex_taken,
   input  logic [31:0]      ex_target,
   output logic             update,
   output logic [31:0]      updatePC,
   output logic [31:0]      updateTarget,
   output logic             mispredicted,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             underflow,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   pred_entry_t push_entry, head;
   logic        full, empty;
   logic [AW:0] count;
   logic        can_pop, push_ok, miss, do_update, branch_res;
   logic [31:0] pred_next, act_next;

   logic             update_q, update_d;
   logic             mispred_q, mispred_d;
   logic             redir_q, redir_d;
   logic [31:0]      upd_pc_q, upd_pc_d;
   logic [31:0]      upd_tgt_q, upd_tgt_d;
   logic [31:0]      redir_pc_q, redir_pc_d;
   logic             uflow_q, uflow_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

   assign push_entry = '{pc: fetch_pc, hit: pred_valid, taken: pred_taken, target: pred_target};

   assign fetch_ready = (count != (AW+1)'(DEPTH));
   assign can_pop     = ex_valid && !empty;
   assign pred_next   = next_pc(head.hit, head.taken, head.target, head.pc);
   assign act_next    = (ex_is_branch && ex_taken) ? ex_target : head.pc + 32'(INSTR_BYTES);
   assign miss        = can_pop && (pred_next != act_next);
   assign do_update   = can_pop && (ex_is_branch || head.hit);
   assign branch_res  = can_pop && ex_is_branch;
   // A pop frees a slot this edge, so a push into a full queue is still safe;
   // anything fetched alongside a mispredict is wrong-path and dropped.
   assign push_ok     = fetch_valid && (fetch_ready || can_pop) && !miss;

   pred_fifo #(
      .DEPTH (DEPTH),
      .T     (pred_entry_t)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push_ok),
      .push_data_i (push_entry),
      .pop_i       (can_pop),
      .flush_i     (miss),
      .head_o      (head),
      .full_o      (full),
      .empty_o     (empty),
      .count_o     (count)
   );

   always_comb begin
      update_d   = do_update;
      mispred_d  = miss;
      redir_d    = miss;
      upd_pc_d   = upd_pc_q;
      upd_tgt_d  = upd_tgt_q;
      redir_pc_d = redir_pc_q;
      uflow_d    = uflow_q || (ex_valid && empty);
      br_cnt_d   = br_cnt_q;
      mp_cnt_d   = mp_cnt_q;
      if (do_update) begin
         upd_pc_d  = head.pc;
         upd_tgt_d = ex_is_branch ? act_next : head.target;
      end
      if (miss) redir_pc_d = act_next;
      if (branch_res && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + CNT_W'(1);
      if (miss && (mp_cnt_q != '1))       mp_cnt_d = mp_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         update_q   <= 1'b0;
         mispred_q  <= 1'b0;
         redir_q    <= 1'b0;
         upd_pc_q   <= '0;
         upd_tgt_q  <= '0;
         redir_pc_q <= '0;
         uflow_q    <= 1'b0;
         br_cnt_q   <= '0;
         mp_cnt_q   <= '0;
      end else begin
         update_q   <= update_d;
         mispred_q  <= mispred_d;
         redir_q    <= redir_d;
         upd_pc_q   <= upd_pc_d;
         upd_tgt_q  <= upd_tgt_d;
         redir_pc_q <= redir_pc_d;
         uflow_q    <= uflow_d;
         br_cnt_q   <= br_cnt_d;
         mp_cnt_q   <= mp_cnt_d;
      end
   end

   assign update           = update_q;
   assign mispredicted     = mispred_q;
   assign redirect_valid   = redir_q;
   assign updatePC         = upd_pc_q;
   assign updateTarget     = upd_tgt_q;
   assign redirect_pc      = redir_pc_q;
   assign underflow        = uflow_q;
   assign branch_count     = br_cnt_q;
   assign mispredict_count = mp_cnt_q;

endmodule

// File: tb/tb_btb_resolve.sv
// Scoreboard bench for btb_resolve: queue-based reference model, strobe monitor.
module tb_btb_resolve;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned MAXC  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             fetch_valid = 1'b0;
   logic             fetch_ready;
   logic [31:0]      fetch_pc = '0;
   logic             pred_valid = 1'b0;
   logic             pred_taken = 1'b0;
   logic [31:0]      pred_target = '0;
   logic             ex_valid = 1'b0;
   logic             ex_is_branch = 1'b0;
   logic             ex_taken = 1'b0;
   logic [31:0]      ex_target = '0;
   logic             update;
   logic [31:0]      updatePC;
   logic [31:0]      updateTarget;
   logic             mispredicted;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic             underflow;
   logic [CNT_W-1:0] branch_count;
   logic [CNT_W-1:0] mispredict_count;

   btb_resolve #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
      .ex_target(ex_target),
      .update(update), .updatePC(updatePC), .updateTarget(updateTarget),
      .mispredicted(mispredicted), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .underflow(underflow),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      bit          hit;
      bit          taken;
      logic [31:0] tgt;
   } m_ent_t;

   typedef struct {
      int unsigned cyc;
      bit          miss;
      logic [31:0] upc;
      logic [31:0] utgt;
      logic [31:0] rpc;
   } exp_t;

   m_ent_t      mq[$];
   exp_t        expq[$];
   int unsigned m_bc, m_mc;
   bit          m_uf;
   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every strobe cycle consumes one expected resolution.
   always @(negedge clk) begin
      if (rst_n && (update || redirect_valid)) begin
         if (expq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_strobe: got update=%0b redirect=%0b expected none", update, redirect_valid);
         end else begin
            exp_t e;
            e = expq.pop_front();
            chk("strobe_cycle", cyc, e.cyc);
            chk("update", {31'b0, update}, 32'd1);
            chk("mispredicted", {31'b0, mispredicted}, {31'b0, e.miss});
            chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, e.miss});
            chk("updatePC", updatePC, e.upc);
            chk("updateTarget", updateTarget, e.utgt);
            if (e.miss) chk("redirect_pc", redirect_pc, e.rpc);
         end
      end
   end

   // One clock of stimulus; model predicts the edge, then state is checked after it.
   task automatic step(input bit fv, input logic [31:0] pc, input bit hit, input bit tk,
                       input logic [31:0] tgt, input bit ev, input bit br, input bit et,
                       input logic [31:0] etgt);
      bit          pop, miss, accept;
      m_ent_t      e;
      logic [31:0] pred_nx, act_nx;
      fetch_valid = fv; fetch_pc = pc; pred_valid = hit; pred_taken = tk; pred_target = tgt;
      ex_valid = ev; ex_is_branch = br; ex_taken = et; ex_target = etgt;

      pop  = ev && (mq.size() > 0);
      miss = 1'b0;
      if (ev && mq.size() == 0) m_uf = 1'b1;
      accept = fv && ((mq.size() < DEPTH) || pop);
      if (pop) begin
         e       = mq.pop_front();
         pred_nx = (e.hit && e.taken) ? e.tgt : e.pc + 32'd4;
         act_nx  = (br && et) ? etgt : e.pc + 32'd4;
         miss    = (pred_nx != act_nx);
         if (br || e.hit)
            expq.push_back('{cyc + 1, miss, e.pc, br ? act_nx : e.tgt, act_nx});
         if (br && m_bc < MAXC) m_bc++;
         if (miss && m_mc < MAXC) m_mc++;
         if (miss) mq.delete();
      end
      if (accept && !miss) mq.push_back('{pc, hit, tk, tgt});

      @(posedge clk);
      #1;
      chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, mq.size() < DEPTH});
      chk("branch_count", 32'(branch_count), m_bc);
      chk("mispredict_count", 32'(mispredict_count), m_mc);
      chk("underflow", {31'b0, underflow}, {31'b0, m_uf});
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic push(input logic [31:0] pc, input bit hit, input bit tk, input logic [31:0] tgt);
      step(1, pc, hit, tk, tgt, 0, 0, 0, 0);
   endtask

   task automatic pop(input bit br, input bit et, input logic [31:0] etgt);
      step(0, 0, 0, 0, 0, 1, br, et, etgt);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      fetch_valid = 0; ex_valid = 0;
      expq.delete();
      mq.delete();
      m_bc = 0; m_mc = 0; m_uf = 0;
      #1;
      chk("rst_update", {31'b0, update}, 32'd0);
      chk("rst_mispredicted", {31'b0, mispredicted}, 32'd0);
      chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
      chk("rst_underflow", {31'b0, underflow}, 32'd0);
      chk("rst_updatePC", updatePC, 32'd0);
      chk("rst_updateTarget", updateTarget, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_branch_count", 32'(branch_count), 32'd0);
      chk("rst_mispredict_count", 32'(mispredict_count), 32'd0);
      chk("rst_fetch_ready", {31'b0, fetch_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_update", {31'b0, update}, 32'd0);
      chk("post_rst_redirect", {31'b0, redirect_valid}, 32'd0);
   endtask

   initial begin
      logic [31:0] r, pc, tgt, etgt;
      bit          fv, hit, tk, ev, br, et;

      #2;
      do_reset();

      // correct taken prediction
      push(32'h100, 1, 1, 32'h200);
      pop(1, 1, 32'h200);
      idle();
      chk("bc_after_correct", 32'(branch_count), 32'd1);

      // cold miss
      push(32'h40, 0, 0, 32'h0);
      pop(1, 1, 32'h80);
      idle();

      // flush with wrong-path push in the same cycle
      push(32'h100, 1, 1, 32'h200);
      push(32'h200, 0, 0, 32'h0);
      push(32'h204, 0, 0, 32'h0);
      step(1, 32'h300, 0, 0, 0, 1, 1, 0, 32'h0);
      chk("flush_ready", {31'b0, fetch_ready}, 32'd1);
      pop(1, 1, 32'h999);
      chk("underflow_after_flush", {31'b0, underflow}, 32'd1);
      idle();

      do_reset();

      // full / backpressure
      for (int i = 0; i < 4; i++) push(32'h10 + 32'(i * 4), 0, 0, 32'h0);
      chk("full_ready", {31'b0, fetch_ready}, 32'd0);
      step(1, 32'h20, 0, 0, 0, 1, 0, 0, 0);
      pop(0, 0, 0);
      chk("ready_after_pop", {31'b0, fetch_ready}, 32'd1);
      for (int i = 0; i < 3; i++) pop(0, 0, 0);

      // stale hit on a non-branch
      push(32'h300, 1, 1, 32'h500);
      pop(0, 0, 0);
      idle();

      // PC wrap at the top of the address space
      push(32'hFFFF_FFFC, 0, 0, 32'h0);
      pop(1, 0, 32'h1234);
      idle();

      // reset in the middle of a burst, with a strobe in flight
      push(32'h500, 1, 0, 32'h600);
      push(32'h504, 0, 0, 32'h0);
      step(1, 32'h508, 0, 0, 0, 1, 1, 1, 32'h700);
      do_reset();

      // randomized traffic; CNT_W=4 makes counter saturation reachable
      for (int n = 0; n < 600; n++) begin
         r   = $urandom();
         fv  = ($urandom_range(0, 99) < 60);
         pc  = {r[31:2], 2'b00};
         if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FFFC;
         hit = $urandom_range(0, 1) == 1;
         tk  = $urandom_range(0, 1) == 1;
         r   = $urandom();
         tgt = ($urandom_range(0, 3) == 0) ? pc + 32'd4 : {r[31:2], 2'b00};
         ev  = ($urandom_range(0, 99) < 50);
         br  = $urandom_range(0, 1) == 1;
         et  = $urandom_range(0, 1) == 1;
         r   = $urandom();
         etgt = {r[31:2], 2'b00};
         if (mq.size() > 0 && $urandom_range(0, 1) == 1) etgt = mq[0].tgt;
         step(fv, pc, hit, tk, tgt, ev, br, et, etgt);
      end
      idle();
      idle();
      chk("scoreboard_drained", expq.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
